// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing generator.
// Scans horizontal/vertical pixel counters at pixel rate (clk / CLK_DIV) and
// produces registered sync, blanking and line/frame markers that stay aligned
// with xcoor/ycoor in the same cycle.
// Optional build macro: VGA_FRAME_CNT_EN adds an 8-bit frame_cnt output.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick,
    output logic [9:0] xcoor,
    output logic [9:0] ycoor,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0] div_cnt;
    logic       tick;
    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    // Next-state counter values; decodes are taken from these so the
    // registered sync/blank outputs line up with the registered coordinates.
    always_comb begin
        tick   = (div_cnt == DIV_LAST);
        x_wrap = (xcoor == H_LAST);
        y_wrap = (ycoor == V_LAST);
        x_nxt  = x_wrap ? 10'd0 : xcoor + 10'd1;
        y_nxt  = ycoor;
        if (x_wrap) begin
            y_nxt = y_wrap ? 10'd0 : ycoor + 10'd1;
        end
    end

    // Pixel-rate divider, counters and registered decodes; everything holds
    // between ticks except the one-cycle pulse outputs, which clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= 2'd0;
            pix_tick    <= 1'b0;
            xcoor       <= 10'd0;
            ycoor       <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= tick ? 2'd0 : div_cnt + 2'd1;
            pix_tick    <= tick;
            line_start  <= tick && x_wrap;
            frame_start <= tick && x_wrap && y_wrap;
            if (tick) begin
                xcoor      <= x_nxt;
                ycoor      <= y_nxt;
                hsync      <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
                vsync      <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
                display_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter advances on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
        end else if (tick && x_wrap && y_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen.
// Instance a: default 640x480 timing, CLK_DIV=1 (horizontal behaviour).
// Instance b: shrunken 15x10 raster, CLK_DIV=1 (vertical, frame, wrap, reset).
// Instance c: shrunken 15x10 raster, CLK_DIV=2 (divider behaviour).
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic       a_tick, a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_tick, c_hs, c_vs, c_de, c_ls, c_fs;
    logic [9:0] c_x, c_y;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] a_fc, b_fc, c_fc;
`endif

    vga_sync_gen u_a (
        .clk(clk), .rst_n(rst_n), .pix_tick(a_tick), .xcoor(a_x), .ycoor(a_y),
        .hsync(a_hs), .vsync(a_vs), .display_on(a_de), .line_start(a_ls),
        .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .pix_tick(b_tick), .xcoor(b_x), .ycoor(b_y),
        .hsync(b_hs), .vsync(b_vs), .display_on(b_de), .line_start(b_ls),
        .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(2)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .pix_tick(c_tick), .xcoor(c_x), .ycoor(c_y),
        .hsync(c_hs), .vsync(c_vs), .display_on(c_de), .line_start(c_ls),
        .frame_start(c_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(c_fc)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp_v);
        end
    endtask

    // one rising edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a_x"}, int'(a_x), 0);
        chk({tag, "_a_y"}, int'(a_y), 0);
        chk({tag, "_a_hs"}, int'(a_hs), 1);
        chk({tag, "_a_vs"}, int'(a_vs), 1);
        chk({tag, "_a_de"}, int'(a_de), 0);
        chk({tag, "_a_ls"}, int'(a_ls), 0);
        chk({tag, "_a_fs"}, int'(a_fs), 0);
        chk({tag, "_a_tick"}, int'(a_tick), 0);
        chk({tag, "_b_x"}, int'(b_x), 0);
        chk({tag, "_b_y"}, int'(b_y), 0);
        chk({tag, "_b_hs"}, int'(b_hs), 1);
        chk({tag, "_b_de"}, int'(b_de), 0);
        chk({tag, "_c_tick"}, int'(c_tick), 0);
`ifdef VGA_FRAME_CNT_EN
        chk({tag, "_b_fc"}, int'(b_fc), 0);
`endif
    endtask

    initial begin
        int a_hs_lo = 0;
        int a_ls_n  = 0;
        int c_ls_n  = 0;
        int b_vs_lo = 0;
        int b_fs_n  = 0;

        #2 rst_n = 1'b0;
        step();
        step();
        chk_reset("rst");
        rst_n = 1'b1;

        for (int e = 1; e <= 38400; e++) begin
            step();
            chk("b_x", int'(b_x), e % 15);
            chk("b_y", int'(b_y), (e / 15) % 10);
            if (e <= 1700) begin
                chk("a_x", int'(a_x), e % 800);
                chk("a_y", int'(a_y), e / 800);
                chk("a_tick", int'(a_tick), 1);
                chk("c_x", int'(c_x), (e / 2) % 15);
                chk("c_tick", int'(c_tick), (e % 2 == 0) ? 1 : 0);
                if (e <= 1600 && !a_hs) a_hs_lo++;
                if (a_ls) a_ls_n++;
                if (c_ls) c_ls_n++;
            end
            if (e <= 150 && !b_vs) b_vs_lo++;
            if (b_fs) begin
                b_fs_n++;
                chk("b_fs_x", int'(b_x), 0);
                chk("b_fs_y", int'(b_y), 0);
                chk("b_fs_ls", int'(b_ls), 1);
            end
            case (e)
                1:     chk("a_de_first", int'(a_de), 1);
                639:   chk("a_de_639_0", int'(a_de), 1);
                640:   chk("a_de_640_0", int'(a_de), 0);
                655:   chk("a_hs_655", int'(a_hs), 1);
                656:   chk("a_hs_656", int'(a_hs), 0);
                751:   chk("a_hs_751", int'(a_hs), 0);
                752:   chk("a_hs_752", int'(a_hs), 1);
                800:   chk("a_ls_800", int'(a_ls), 1);
                801:   chk("a_ls_801", int'(a_ls), 0);
                8:     chk("b_de_8_0", int'(b_de), 0);
                9:     chk("b_hs_9", int'(b_hs), 1);
                10:    chk("b_hs_10", int'(b_hs), 0);
                12:    chk("b_hs_12", int'(b_hs), 0);
                13:    chk("b_hs_13", int'(b_hs), 1);
                82:    chk("b_de_7_5", int'(b_de), 1);
                90:    chk("b_de_0_6", int'(b_de), 0);
                104:   chk("b_vs_6", int'(b_vs), 1);
                105:   chk("b_vs_7", int'(b_vs), 0);
                149:   chk("b_de_14_9", int'(b_de), 0);
                150:   chk("b_fs_150", int'(b_fs), 1);
                151:   chk("b_fs_151", int'(b_fs), 0);
`ifdef VGA_FRAME_CNT_EN
                451:   chk("b_fc_3", int'(b_fc), 3);
                38399: chk("b_fc_255", int'(b_fc), 255);
                38400: chk("b_fc_wrap", int'(b_fc), 0);
`endif
                default: ;
            endcase
        end

        chk("a_hs_lo_cnt", a_hs_lo, 192);
        chk("a_ls_cnt", a_ls_n, 2);
        chk("c_ls_cnt", c_ls_n, 56);
        chk("b_vs_lo_cnt", b_vs_lo, 30);
        chk("b_fs_cnt", b_fs_n, 256);

        // move b to (4,3) mid-frame, then reset asynchronously between edges
        repeat (49) step();
        chk("pre_rst_b_x", int'(b_x), 4);
        chk("pre_rst_b_y", int'(b_y), 3);
        #3 rst_n = 1'b0;
        #1;
        chk_reset("async");
        repeat (3) step();
        chk_reset("hold");
        rst_n = 1'b1;
        step();
        chk("rel1_b_x", int'(b_x), 1);
        chk("rel1_b_y", int'(b_y), 0);
        chk("rel1_b_tick", int'(b_tick), 1);
        chk("rel1_c_x", int'(c_x), 0);
        chk("rel1_c_tick", int'(c_tick), 0);
        step();
        chk("rel2_c_x", int'(c_x), 1);
        chk("rel2_c_tick", int'(c_tick), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
